// File: rtl/cmd_decoder_pkg.sv
// rtl/cmd_decoder_pkg.sv - shared state encoding, response codes and header layout
package cmd_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX_DATA = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_TX      = 2'd3
  } state_e;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;

  localparam int HDR_WR_BIT   = 7;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_W   = 4;

  function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_LSB +: HDR_ADDR_W];
  endfunction

endpackage

// File: rtl/cmd_decoder_cfg_regfile.sv
// rtl/cmd_decoder_cfg_regfile.sv - configuration register bank with one write port and flat read bus
module cfg_regfile
  import cmd_decoder_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [HDR_ADDR_W-1:0] waddr,
  input  logic [W-1:0]          wdata,
  output logic [NUM_REGS*W-1:0] regs
);

  logic [NUM_REGS*W-1:0] regs_d, regs_q;

  // Replace only the addressed slot; every other register holds.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (we && (waddr == HDR_ADDR_W'(i))) begin
        regs_d[i*W +: W] = wdata;
      end
    end
  end

  // Register storage, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign regs = regs_q;

endmodule

// File: rtl/cmd_decoder.sv
// rtl/cmd_decoder.sv - byte-stream packet parser, response shifter and timeout for config registers
module cmd_decoder
  import cmd_decoder_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int DATA_BYTES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx,
  input  logic [7:0]                       data_rx,
  output logic                             tx_req,
  output logic [7:0]                       tx_data,
  input  logic                             tx_ack,
  output logic [NUM_REGS*8*DATA_BYTES-1:0] cfg_regs,
  output logic                             cfg_wr,
  output logic [3:0]                       cfg_addr,
  output logic [7:0]                       err_count
);

  localparam int W  = 8 * DATA_BYTES;
  localparam int CW = $clog2(DATA_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT);

  state_e          state_d, state_q;
  logic [3:0]      addr_d, addr_q;
  logic [CW-1:0]   cnt_d, cnt_q;
  logic [W-1:0]    shift_d, shift_q;
  logic [TW-1:0]   timer_d, timer_q;
  logic [W-1:0]    resp_d, resp_q;
  logic [CW-1:0]   rem_d, rem_q;
  logic            tx_req_d, tx_req_q;
  logic [7:0]      tx_data_d, tx_data_q;
  logic            cfg_wr_d, cfg_wr_q;
  logic [3:0]      cfg_addr_d, cfg_addr_q;
  logic [7:0]      err_d, err_q;
  logic            err_hit;
  logic            rf_we;
  logic [W-1:0]    rd_data;

  function automatic logic addr_ok(input logic [3:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  cfg_regfile #(
    .NUM_REGS (NUM_REGS),
    .W        (W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (addr_q),
    .wdata (shift_q),
    .regs  (cfg_regs)
  );

  // Read-port mux addressed straight from the incoming header byte.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hdr_addr(data_rx) == 4'(i)) begin
        rd_data = cfg_regs[i*W +: W];
      end
    end
  end

  // Next-state logic: packet parsing, commit, response shifting and error counting.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    timer_d    = timer_q;
    resp_d     = resp_q;
    rem_d      = rem_q;
    tx_req_d   = tx_req_q;
    tx_data_d  = tx_data_q;
    cfg_wr_d   = 1'b0;
    cfg_addr_d = cfg_addr_q;
    err_d      = err_q;
    err_hit    = 1'b0;
    rf_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx) begin
          addr_d = hdr_addr(data_rx);
          if (data_rx[HDR_WR_BIT]) begin
            state_d = ST_RX_DATA;
            cnt_d   = '0;
            timer_d = '0;
          end else begin
            state_d  = ST_TX;
            tx_req_d = 1'b1;
            resp_d   = rd_data;
            if (addr_ok(hdr_addr(data_rx))) begin
              tx_data_d = data_rx;
              rem_d     = CW'(DATA_BYTES);
            end else begin
              tx_data_d = RESP_NAK;
              rem_d     = '0;
              err_hit   = 1'b1;
            end
          end
        end
      end
      ST_RX_DATA: begin
        if (rx) begin
          shift_d = W'({shift_q, data_rx});
          cnt_d   = cnt_q + CW'(1);
          timer_d = '0;
          if (cnt_q == CW'(DATA_BYTES - 1)) begin
            state_d = ST_COMMIT;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_hit = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_COMMIT: begin
        err_hit  = rx;
        tx_req_d = 1'b1;
        rem_d    = '0;
        state_d  = ST_TX;
        if (addr_ok(addr_q)) begin
          rf_we      = 1'b1;
          cfg_wr_d   = 1'b1;
          cfg_addr_d = addr_q;
          tx_data_d  = RESP_ACK;
        end else begin
          tx_data_d = RESP_NAK;
          err_hit   = 1'b1;
        end
      end
      ST_TX: begin
        err_hit = rx;
        if (tx_ack) begin
          if (rem_q != '0) begin
            tx_data_d = resp_q[W-1 -: 8];
            resp_d    = resp_q << 8;
            rem_d     = rem_q - CW'(1);
          end else begin
            tx_req_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (err_hit && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // State and registered outputs; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      timer_q    <= '0;
      resp_q     <= '0;
      rem_q      <= '0;
      tx_req_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      cfg_wr_q   <= 1'b0;
      cfg_addr_q <= '0;
      err_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      timer_q    <= timer_d;
      resp_q     <= resp_d;
      rem_q      <= rem_d;
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
      cfg_wr_q   <= cfg_wr_d;
      cfg_addr_q <= cfg_addr_d;
      err_q      <= err_d;
    end
  end

  assign tx_req    = tx_req_q;
  assign tx_data   = tx_data_q;
  assign cfg_wr    = cfg_wr_q;
  assign cfg_addr  = cfg_addr_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// tb/tb_cmd_decoder.sv - scoreboard bench for cmd_decoder with randomized packets
module tb_cmd_decoder;

  localparam int NUM_REGS   = 8;
  localparam int DATA_BYTES = 4;
  localparam int TIMEOUT    = 64;
  localparam int W          = 8 * DATA_BYTES;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  rx = 1'b0;
  logic [7:0]            data_rx = 8'h00;
  logic                  tx_req;
  logic [7:0]            tx_data;
  logic                  tx_ack = 1'b0;
  logic [NUM_REGS*W-1:0] cfg_regs;
  logic                  cfg_wr;
  logic [3:0]            cfg_addr;
  logic [7:0]            err_count;

  cmd_decoder #(
    .NUM_REGS   (NUM_REGS),
    .DATA_BYTES (DATA_BYTES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_rx   (data_rx),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_ack    (tx_ack),
    .cfg_regs  (cfg_regs),
    .cfg_wr    (cfg_wr),
    .cfg_addr  (cfg_addr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         wr_addr_q[$];
  logic [W-1:0] wr_data_q[$];
  logic [W-1:0] model_regs[NUM_REGS];
  int         model_err = 0;
  bit         hold_ack = 1'b0;
  bit         cur_valid = 1'b0;
  logic [7:0] cur_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_valid(input logic [7:0] h);
    return int'(h[3:0]) < NUM_REGS;
  endfunction

  function automatic int exp_err();
    return (model_err > 255) ? 255 : model_err;
  endfunction

  // Response monitor: pops one expected byte per presented byte and acknowledges it.
  initial begin : tx_monitor
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      tx_ack = 1'b0;
      if (!rst) begin
        cur_valid = 1'b0;
      end else if (tx_req) begin
        if (!cur_valid) begin
          cur_valid = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got byte %0h with no response pending at %0t", tx_data, $time);
            cur_byte = tx_data;
          end else begin
            cur_byte = exp_q.pop_front();
            chk("tx_byte", 32'(tx_data), 32'(cur_byte));
          end
          wait_cnt = $urandom_range(0, 2);
        end else begin
          chk("tx_hold", 32'(tx_data), 32'(cur_byte));
        end
        if (!hold_ack) begin
          if (wait_cnt == 0) begin
            tx_ack    = 1'b1;
            cur_valid = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        tx_ack = 1'b1;
      end
    end
  end

  // Write monitor: every cfg_wr pulse must match a pending expected write.
  initial begin : wr_monitor
    int a;
    logic [W-1:0] d;
    forever begin
      @(negedge clk);
      if (rst && cfg_wr) begin
        if (wr_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cfg_wr_unexpected: got write to %0d with none pending at %0t", cfg_addr, $time);
        end else begin
          a = wr_addr_q.pop_front();
          d = wr_data_q.pop_front();
          chk("cfg_addr", 32'(cfg_addr), 32'(a));
          chk("cfg_wdata", cfg_regs[a*W +: W], d);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic put_byte(input logic [7:0] b);
    rx      = 1'b1;
    data_rx = b;
    @(negedge clk);
    rx      = 1'b0;
  endtask

  task automatic check_state();
    for (int i = 0; i < NUM_REGS; i++) begin
      chk("reg", cfg_regs[i*W +: W], model_regs[i]);
    end
    chk("err_count", 32'(err_count), 32'(exp_err()));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !tx_req && !cur_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got %0d bytes pending, tx_req=%0b, required drained", exp_q.size(), tx_req);
    end
    check_state();
  endtask

  task automatic send_write(input logic [7:0] hdr, input logic [W-1:0] d, input int gap, input bit drop);
    int a;
    a = int'(hdr[3:0]);
    if (addr_valid(hdr)) begin
      model_regs[a] = d;
      wr_addr_q.push_back(a);
      wr_data_q.push_back(d);
      exp_q.push_back(8'hA5);
      if (drop) model_err++;
    end else begin
      exp_q.push_back(8'hEE);
      model_err++;
    end
    put_byte(hdr);
    for (int i = DATA_BYTES - 1; i >= 0; i--) begin
      repeat (gap) @(negedge clk);
      put_byte(d[i*8 +: 8]);
    end
    chk("commit_no_req", 32'(tx_req), 32'd0);
    if (drop) put_byte(8'h5A);
    else @(negedge clk);
    chk("commit_req", 32'(tx_req), 32'd1);
    chk("commit_wr", 32'(cfg_wr), 32'(addr_valid(hdr)));
  endtask

  task automatic send_read(input logic [7:0] hdr);
    int a;
    a = int'(hdr[3:0]);
    if (addr_valid(hdr)) begin
      exp_q.push_back(hdr);
      for (int i = DATA_BYTES - 1; i >= 0; i--) exp_q.push_back(model_regs[a][i*8 +: 8]);
    end else begin
      exp_q.push_back(8'hEE);
      model_err++;
    end
    put_byte(hdr);
    chk("read_req", 32'(tx_req), 32'd1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_cfg_wr", 32'(cfg_wr), 32'd0);
    chk("rst_cfg_addr", 32'(cfg_addr), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) chk("rst_reg", cfg_regs[i*W +: W], 32'd0);
  endtask

  initial begin : stimulus
    logic [7:0]   h;
    logic [W-1:0] d;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    send_write(8'h83, 32'h12345678, 0, 1'b0);
    wait_idle();
    send_read(8'h03);
    wait_idle();
    send_write(8'h81, 32'hCAFEF00D, 1, 1'b0);
    wait_idle();
    send_write(8'h8F, 32'hDEADBEEF, 0, 1'b0);
    wait_idle();

    // partial write abandoned by the idle timeout
    put_byte(8'h81);
    put_byte(8'h99);
    put_byte(8'h88);
    repeat (TIMEOUT) @(negedge clk);
    model_err++;
    chk("timeout_err", 32'(err_count), 32'(exp_err()));
    chk("timeout_no_req", 32'(tx_req), 32'd0);
    send_read(8'h01);
    wait_idle();

    // one idle cycle short of the timeout keeps the packet alive
    send_write(8'hF2, 32'h0BADCAFE, TIMEOUT - 1, 1'b0);
    wait_idle();
    // byte dropped during COMMIT, alone and coinciding with a bad address
    send_write(8'h84, 32'h44332211, 0, 1'b1);
    wait_idle();
    send_write(8'h8A, 32'h55667788, 0, 1'b1);
    wait_idle();

    for (int k = 0; k < 40; k++) begin
      h = 8'($urandom);
      d = W'($urandom);
      if (h[7]) send_write(h, d, $urandom_range(0, 2), $urandom_range(0, 3) == 0);
      else send_read(h);
      wait_idle();
    end

    // strobes during a held response are dropped and counted one by one
    hold_ack = 1'b1;
    send_read(8'h03);
    for (int i = 0; i < 5; i++) begin
      put_byte(8'($urandom));
      model_err++;
      chk("drop_err", 32'(err_count), 32'(exp_err()));
    end
    hold_ack = 1'b0;
    wait_idle();

    // saturate the error counter
    hold_ack = 1'b1;
    send_read(8'h02);
    for (int i = 0; i < 300; i++) begin
      put_byte(8'($urandom));
      model_err++;
    end
    chk("err_saturate", 32'(err_count), 32'd255);
    hold_ack = 1'b0;
    wait_idle();

    // reset in the middle of a write payload
    put_byte(8'h85);
    put_byte(8'h11);
    put_byte(8'h22);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs();
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
    model_err = 0;
    exp_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_write(8'h85, 32'hA1B2C3D4, 0, 1'b0);
    wait_idle();
    send_read(8'h05);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
